// File: rtl/note_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | note_sched_pkg                                                   |
// | Shared sizes and lane state encoding for the note lane scheduler |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package note_sched_pkg;

    localparam int NUM_LANES  = 37;
    localparam int TIME_W     = 16;
    localparam int LANE_IDX_W = 6;

    typedef enum logic [2:0] {
        LANE_IDLE = 3'd0,
        LANE_REQ  = 3'd1,
        LANE_HOLD = 3'd2,
        LANE_PEND = 3'd3,
        LANE_DONE = 3'd4
    } lane_state_e;

endpackage
`default_nettype wire

// File: rtl/note_lane_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | note_lane_fsm                                                    |
// | One lane: fetch note time, wait for look-ahead, request a spawn  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module note_lane_fsm
    import note_sched_pkg::*;
#(
    parameter int NOTE_W  = 16,
    parameter int LEAD    = 200,
    parameter bit LANE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [NOTE_W-1:0] song_time_i,
    input  logic              avail_i,
    input  logic [NOTE_W-1:0] link_i,
    input  logic              grant_i,
    output logic              request_o,
    output logic              pend_o,
    output logic              done_o,
    output logic [NOTE_W-1:0] note_time_o
);

    localparam logic [NOTE_W:0] LEAD_X = LEAD[NOTE_W:0];

    lane_state_e       state_q, state_d;
    logic [NOTE_W-1:0] note_time_q, note_time_d;
    logic [NOTE_W-1:0] prev_time_q, prev_time_d;
    logic              request_q, request_d;
    logic              reached;

    // One extra bit so a late note near the top of the range never wraps.
    assign reached = ({1'b0, song_time_i} + LEAD_X) >= {1'b0, note_time_q};

    always_comb begin
        state_d     = state_q;
        note_time_d = note_time_q;
        prev_time_d = prev_time_q;
        case (state_q)
            LANE_IDLE: if (start_i && LANE_EN) state_d = LANE_REQ;
            LANE_REQ: begin
                if (avail_i) begin
                    // A zero or non-increasing time marks the end of the list.
                    if ((link_i == '0) || (link_i <= prev_time_q)) begin
                        state_d = LANE_DONE;
                    end else begin
                        note_time_d = link_i;
                        prev_time_d = link_i;
                        state_d     = LANE_HOLD;
                    end
                end
            end
            LANE_HOLD: if (reached) state_d = LANE_PEND;
            LANE_PEND: if (grant_i) state_d = LANE_REQ;
            LANE_DONE: state_d = LANE_DONE;
            default:   state_d = LANE_IDLE;
        endcase
    end

    assign request_d = (state_d == LANE_REQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LANE_IDLE;
            note_time_q <= '0;
            prev_time_q <= '0;
            request_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            note_time_q <= note_time_d;
            prev_time_q <= prev_time_d;
            request_q   <= request_d;
        end
    end

    assign request_o   = request_q;
    assign pend_o      = (state_q == LANE_PEND);
    assign done_o      = (state_q == LANE_DONE);
    assign note_time_o = note_time_q;

endmodule
`default_nettype wire

// File: rtl/note_lane_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | note_lane_scheduler                                              |
// | Per-lane note fetch with round-robin merge into a spawn stream   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module note_lane_scheduler #(
    parameter int                   NUM_LANES = note_sched_pkg::NUM_LANES,
    parameter int                   TIME_W    = note_sched_pkg::TIME_W,
    parameter int                   LEAD      = 200,
    parameter logic [NUM_LANES-1:0] LANE_MASK = 37'h0_9500_0000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [TIME_W-1:0]                     song_time,
    input  logic [NUM_LANES-1:0]                  metadata_available,
    input  logic [NUM_LANES*TIME_W-1:0]           metadata_link,
    output logic [NUM_LANES-1:0]                  metadata_request,
    output logic                                  spawn_valid,
    output logic [note_sched_pkg::LANE_IDX_W-1:0] spawn_lane,
    output logic [TIME_W-1:0]                     spawn_time,
    input  logic                                  spawn_ready,
    output logic                                  lanes_done
);

    import note_sched_pkg::*;

    logic [NUM_LANES-1:0]  lane_pend;
    logic [NUM_LANES-1:0]  lane_done;
    logic [NUM_LANES-1:0]  lane_grant;
    logic [TIME_W-1:0]     lane_time [NUM_LANES];

    logic [LANE_IDX_W-1:0] ptr_q, ptr_d;
    logic [LANE_IDX_W-1:0] pick_idx;
    logic [LANE_IDX_W-1:0] scan_sel;
    logic                  pick_found;
    logic                  load_en;
    int                    scan_idx;

    logic                  spawn_valid_q, spawn_valid_d;
    logic [LANE_IDX_W-1:0] spawn_lane_q, spawn_lane_d;
    logic [TIME_W-1:0]     spawn_time_q, spawn_time_d;
    logic                  lanes_done_q;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            note_lane_fsm #(
                .NOTE_W  (TIME_W),
                .LEAD    (LEAD),
                .LANE_EN (LANE_MASK[i])
            ) u_fsm (
                .clk         (clk),
                .reset       (reset),
                .start_i     (start),
                .song_time_i (song_time),
                .avail_i     (metadata_available[i]),
                .link_i      (metadata_link[i*TIME_W +: TIME_W]),
                .grant_i     (lane_grant[i]),
                .request_o   (metadata_request[i]),
                .pend_o      (lane_pend[i]),
                .done_o      (lane_done[i]),
                .note_time_o (lane_time[i])
            );
        end
    endgenerate

    // Scan starts at the pointer and wraps, so the first hit is the round-robin winner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        scan_sel   = '0;
        for (int off = 0; off < NUM_LANES; off++) begin
            scan_idx = int'(ptr_q) + off;
            if (scan_idx >= NUM_LANES) begin
                scan_idx = scan_idx - NUM_LANES;
            end
            scan_sel = LANE_IDX_W'(scan_idx);
            if (!pick_found && lane_pend[scan_sel]) begin
                pick_found = 1'b1;
                pick_idx   = scan_sel;
            end
        end
    end

    assign load_en    = !spawn_valid_q || spawn_ready;
    assign lane_grant = (load_en && pick_found) ? (NUM_LANES'(1) << pick_idx) : '0;

    always_comb begin
        spawn_valid_d = spawn_valid_q;
        spawn_lane_d  = spawn_lane_q;
        spawn_time_d  = spawn_time_q;
        ptr_d         = ptr_q;
        if (load_en) begin
            spawn_valid_d = pick_found;
            if (pick_found) begin
                spawn_lane_d = pick_idx;
                spawn_time_d = lane_time[pick_idx];
                ptr_d        = (pick_idx == LANE_IDX_W'(NUM_LANES - 1)) ? '0
                                                                         : pick_idx + LANE_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spawn_valid_q <= 1'b0;
            spawn_lane_q  <= '0;
            spawn_time_q  <= '0;
            ptr_q         <= '0;
            lanes_done_q  <= 1'b0;
        end else begin
            spawn_valid_q <= spawn_valid_d;
            spawn_lane_q  <= spawn_lane_d;
            spawn_time_q  <= spawn_time_d;
            ptr_q         <= ptr_d;
            lanes_done_q  <= &(lane_done | ~LANE_MASK);
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign spawn_lane  = spawn_lane_q;
    assign spawn_time  = spawn_time_q;
    assign lanes_done  = lanes_done_q;

endmodule
`default_nettype wire
